// File: rtl/cgra_run_ctrl.sv
// Run sequencer for the CGRA top: launches a batch of kernel invocations over the
// Computation_Start/Computation_Done four-phase handshake. Optional timeout: CGRA_RUN_TIMEOUT_EN.
module cgra_run_ctrl #(
  parameter int CNT_WIDTH      = 16,
  parameter int CYC_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic                 Run_Req,
  input  logic [CNT_WIDTH-1:0] Run_Count,
  input  logic                 Data_Ready,
  input  logic                 Computation_Done,
  output logic                 Computation_Start,
  output logic                 Run_Busy,
  output logic                 Iter_Done,
  output logic [CNT_WIDTH-1:0] Iter_Index,
  output logic                 Run_Done,
  output logic                 Run_Err,
  output logic [CYC_WIDTH-1:0] Run_Cycles
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    START_HI  = 2'd2,
    START_LO  = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic [CNT_WIDTH-1:0] index_reg, index_next;
  logic [CYC_WIDTH-1:0] cycles_reg, cycles_next;
  logic                 start_reg, start_next;
  logic                 iter_done_reg, iter_done_next;
  logic                 run_done_reg, run_done_next;
  logic                 accept;
  logic                 last_iter;
  logic                 timeout_hit;

  assign accept    = (state_reg == IDLE) && Run_Req;
  assign last_iter = (index_reg == count_reg - CNT_WIDTH'(1));

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    index_next     = index_reg;
    iter_done_next = 1'b0;
    run_done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Run_Req) begin
          count_next = Run_Count;
          index_next = '0;
          // A zero-length batch completes immediately without touching the CGRA.
          if (Run_Count == '0) run_done_next = 1'b1;
          else                 state_next    = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (Data_Ready && !Computation_Done) state_next = START_HI;
      end
      START_HI: begin
        if (Computation_Done) begin
          state_next = START_LO;
        end else if (timeout_hit) begin
          run_done_next = 1'b1;
          state_next    = IDLE;
        end
      end
      START_LO: begin
        if (!Computation_Done) begin
          iter_done_next = 1'b1;
          index_next     = index_reg + CNT_WIDTH'(1);
          if (last_iter) begin
            run_done_next = 1'b1;
            state_next    = IDLE;
          end else begin
            state_next = WAIT_DATA;
          end
        end else if (timeout_hit) begin
          run_done_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Start is a registered copy of the next state, so it falls on the same edge the FSM leaves START_HI.
  assign start_next = (state_next == START_HI);

  always_comb begin
    cycles_next = cycles_reg;
    if (accept) begin
      cycles_next = '0;
    end else if ((state_reg != IDLE) && (cycles_reg != {CYC_WIDTH{1'b1}})) begin
      cycles_next = cycles_reg + CYC_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      index_reg     <= '0;
      cycles_reg    <= '0;
      start_reg     <= 1'b0;
      iter_done_reg <= 1'b0;
      run_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      index_reg     <= index_next;
      cycles_reg    <= cycles_next;
      start_reg     <= start_next;
      iter_done_reg <= iter_done_next;
      run_done_reg  <= run_done_next;
    end
  end

`ifdef CGRA_RUN_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             run_err_reg, run_err_next;
  logic             in_handshake;

  assign in_handshake = (state_reg == START_HI) || (state_reg == START_LO);

  // The counter hits zero on the edge that leaves the state, so Start stays high TIMEOUT_CYCLES clocks.
  assign timeout_hit = in_handshake && (tmo_reg == TMO_W'(1));

  always_comb begin
    tmo_next = tmo_reg;
    if ((state_next != state_reg) &&
        ((state_next == START_HI) || (state_next == START_LO))) begin
      tmo_next = TMO_LOAD;
    end else if (in_handshake && (tmo_reg != '0)) begin
      tmo_next = tmo_reg - TMO_W'(1);
    end
  end

  always_comb begin
    run_err_next = run_err_reg;
    if (accept) begin
      run_err_next = 1'b0;
    end else if (timeout_hit &&
                 (((state_reg == START_HI) && !Computation_Done) ||
                  ((state_reg == START_LO) &&  Computation_Done))) begin
      run_err_next = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      tmo_reg     <= '0;
      run_err_reg <= 1'b0;
    end else begin
      tmo_reg     <= tmo_next;
      run_err_reg <= run_err_next;
    end
  end

  assign Run_Err = run_err_reg;
`else
  // No timeout hardware: the handshake waits forever; the parameter only stays on the interface.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign Run_Err     = 1'b0;
`endif

  assign Computation_Start = start_reg;
  assign Run_Busy          = (state_reg != IDLE);
  assign Iter_Done         = iter_done_reg;
  assign Iter_Index        = index_reg;
  assign Run_Done          = run_done_reg;
  assign Run_Cycles        = cycles_reg;

endmodule
